speed_ctrl: RTL and testbench

Decides, cycle by cycle, whether the 65816 runs from the high-speed or the host (low-speed) clock, and drives the `hsclk_sel` / `cpuclk_div_sel` inputs of the clock-control stage directly downstream. It decodes each valid CPU bus cycle, holds a CPU-writable speed configuration register, and sequences every clock changeover against the `hsclk_selected` feedback. While a changeover is in flight it withholds `cpu_rdy` so the bus cycle is stretched.

---
 rtl/speed_ctrl.sv | 117 +++++++++++
 tb/tb_speed_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_ctrl.sv
// speed_ctrl: picks high-speed vs host clock per CPU bus cycle.
// Optional holdoff counter built when SPEEDCTRL_HOLDOFF_EN is defined.
module speed_ctrl #(
  parameter int          HOLDOFF_CYCLES = 8,
  parameter logic [23:0] CFG_ADR        = 24'hFF0000
) (
  input  logic        cpuclk_in,
  input  logic        rst,
  input  logic [23:0] cpu_adr,
  input  logic        cpu_vda,
  input  logic        cpu_vpa,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_data,
  input  logic        hsclk_selected,
  output logic        hsclk_sel,
  output logic [1:0]  cpuclk_div_sel,
  output logic        cpu_rdy,
  output logic [7:0]  cfg_q
);

  localparam logic [1:0] SLOW    = 2'b00;
  localparam logic [1:0] GO_FAST = 2'b01;
  localparam logic [1:0] FAST    = 2'b10;
  localparam logic [1:0] GO_SLOW = 2'b11;

  if (HOLDOFF_CYCLES < 0 || HOLDOFF_CYCLES > 15) begin : g_ho_range
    $error("HOLDOFF_CYCLES must be 0..15");
  end

  logic [1:0] state;
  logic       cyc_vld;
  logic       local_ram;
  logic       host_cyc;
  logic       fast_cyc;
  logic       cfg_wr;
  logic       ho_zero;
  logic       go_fast;
  logic       go_slow;

  assign cyc_vld   = cpu_vda | cpu_vpa;
  // Low-RAM window in bank 0 stays on the fast clock when enabled.
  assign local_ram = cfg_q[2] & ~cpu_adr[15];
  assign host_cyc  = cyc_vld & (cpu_adr[23:16] == 8'h00) & ~local_ram;
  assign fast_cyc  = cyc_vld & ~host_cyc;
  assign cfg_wr    = cyc_vld & ~cpu_rnw & (cpu_adr == CFG_ADR);

  assign go_fast = (state == SLOW) & fast_cyc & cfg_q[3] & ho_zero;
  assign go_slow = (state == FAST) & (host_cyc | ~cfg_q[3]);

  assign cpu_rdy = ~((state == GO_FAST) | (state == GO_SLOW) |
                     go_fast | go_slow);

`ifdef SPEEDCTRL_HOLDOFF_EN
  localparam logic [3:0] HO_LOAD = 4'(HOLDOFF_CYCLES);

  logic [3:0] holdoff;

  always_ff @(posedge cpuclk_in) begin
    if (rst) begin
      holdoff <= '0;
    end else if (state == GO_SLOW && !hsclk_selected) begin
      holdoff <= HO_LOAD;
    end else if (state == SLOW) begin
      if (host_cyc)
        holdoff <= HO_LOAD;
      else if (holdoff != 4'd0)
        holdoff <= holdoff - 4'd1;
    end
  end

  assign ho_zero = (holdoff == 4'd0);
`else
  assign ho_zero = 1'b1;
`endif

  always_ff @(posedge cpuclk_in) begin
    if (rst)
      cfg_q <= 8'h03;
    else if (cfg_wr)
      cfg_q <= cpu_data;
  end

  // Divider only follows cfg while the low-speed clock runs.
  always_ff @(posedge cpuclk_in) begin
    if (rst) begin
      state          <= SLOW;
      hsclk_sel      <= 1'b0;
      cpuclk_div_sel <= 2'b11;
    end else begin
      unique case (state)
        SLOW: begin
          cpuclk_div_sel <= cfg_q[1:0];
          if (go_fast) begin
            hsclk_sel <= 1'b1;
            state     <= GO_FAST;
          end
        end
        GO_FAST: begin
          if (hsclk_selected)
            state <= FAST;
        end
        FAST: begin
          if (go_slow) begin
            hsclk_sel <= 1'b0;
            state     <= GO_SLOW;
          end
        end
        GO_SLOW: begin
          if (!hsclk_selected)
            state <= SLOW;
        end
        default: state <= SLOW;
      endcase
    end
  end

endmodule

// File: tb/tb_speed_ctrl.sv
// Self-checking bench for speed_ctrl: per-cycle stimulus rows with
// expected outputs queued at drive time and compared mid-cycle.
module tb_speed_ctrl;

`ifdef SPEEDCTRL_HOLDOFF_EN
  localparam int HO = 8;
`else
  localparam int HO = 0;
`endif

  logic        cpuclk_in;
  logic        rst;
  logic [23:0] cpu_adr;
  logic        cpu_vda;
  logic        cpu_vpa;
  logic        cpu_rnw;
  logic [7:0]  cpu_data;
  logic        hsclk_selected;
  logic        hsclk_sel;
  logic [1:0]  cpuclk_div_sel;
  logic        cpu_rdy;
  logic [7:0]  cfg_q;

  speed_ctrl #(
    .HOLDOFF_CYCLES(8),
    .CFG_ADR(24'hFF0000)
  ) dut (
    .cpuclk_in(cpuclk_in),
    .rst(rst),
    .cpu_adr(cpu_adr),
    .cpu_vda(cpu_vda),
    .cpu_vpa(cpu_vpa),
    .cpu_rnw(cpu_rnw),
    .cpu_data(cpu_data),
    .hsclk_selected(hsclk_selected),
    .hsclk_sel(hsclk_sel),
    .cpuclk_div_sel(cpuclk_div_sel),
    .cpu_rdy(cpu_rdy),
    .cfg_q(cfg_q)
  );

  initial cpuclk_in = 1'b0;
  always #5 cpuclk_in = ~cpuclk_in;

  typedef struct packed {
    logic        r;
    logic [23:0] adr;
    logic        vda;
    logic        vpa;
    logic        rnw;
    logic [7:0]  data;
    logic        fb;
  } stim_t;

  typedef logic [11:0] exp_t;

  stim_t ps[$];
  exp_t  pe[$];
  exp_t  sb[$];
  int    total = 0;
  int    bad = 0;

  function automatic stim_t idle(logic fb);
    return {1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 8'h00, fb};
  endfunction

  function automatic stim_t rd(logic [23:0] a, logic fb);
    return {1'b0, a, 1'b1, 1'b0, 1'b1, 8'h00, fb};
  endfunction

  function automatic stim_t fetch(logic [23:0] a, logic fb);
    return {1'b0, a, 1'b0, 1'b1, 1'b1, 8'h00, fb};
  endfunction

  function automatic stim_t wr(logic [7:0] d, logic fb);
    return {1'b0, 24'hFF0000, 1'b1, 1'b0, 1'b0, d, fb};
  endfunction

  function automatic exp_t ex(logic hs, logic [1:0] dv, logic rdy,
                              logic [7:0] cf);
    return {hs, dv, rdy, cf};
  endfunction

  task automatic add(stim_t s, exp_t e);
    ps.push_back(s);
    pe.push_back(e);
  endtask

  task automatic drive(stim_t s);
    rst            = s.r;
    cpu_adr        = s.adr;
    cpu_vda        = s.vda;
    cpu_vpa        = s.vpa;
    cpu_rnw        = s.rnw;
    cpu_data       = s.data;
    hsclk_selected = s.fb;
  endtask

  // h fast reads blocked by holdoff, then the switch and a 1-wait ack.
  task automatic to_fast(int h, logic [1:0] dv, logic [7:0] cf);
    for (int i = 0; i < h; i++)
      add(rd(24'h010000, 1'b0), ex(1'b0, dv, 1'b1, cf));
    add(rd(24'h010000, 1'b0), ex(1'b0, dv, 1'b0, cf));
    add(idle(1'b0), ex(1'b1, dv, 1'b0, cf));
    add(idle(1'b1), ex(1'b1, dv, 1'b0, cf));
  endtask

  task automatic test_reset();
    exp_t got;
    exp_t want;
    int   row = 0;
    drive({1'b1, 24'h000000, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0});
    @(posedge cpuclk_in);
    #1;
    add(idle(1'b0), ex(1'b0, 2'b11, 1'b1, 8'h03));
    add(wr(8'h08, 1'b0), ex(1'b0, 2'b11, 1'b1, 8'h03));
    add(rd(24'h010000, 1'b0), ex(1'b0, 2'b11, 1'b0, 8'h08));
    add({1'b1, 24'h000000, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0},
        ex(1'b1, 2'b00, 1'b0, 8'h08));
    add(idle(1'b0), ex(1'b0, 2'b11, 1'b1, 8'h03));
    while (ps.size() > 0) begin
      drive(ps.pop_front());
      sb.push_back(pe.pop_front());
      @(negedge cpuclk_in);
      got  = {hsclk_sel, cpuclk_div_sel, cpu_rdy, cfg_q};
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset[%0d]: got hs=%b div=%b rdy=%b cfg=%h want hs=%b div=%b rdy=%b cfg=%h",
                 row, got[11], got[10:9], got[8], got[7:0],
                 want[11], want[10:9], want[8], want[7:0]);
      end
      row++;
      @(posedge cpuclk_in);
      #1;
    end
  endtask

  task automatic test_fast();
    exp_t got;
    exp_t want;
    int   row = 0;
    add(wr(8'h0A, 1'b0), ex(1'b0, 2'b11, 1'b1, 8'h03));
    add(idle(1'b0), ex(1'b0, 2'b11, 1'b1, 8'h0A));
    add(rd(24'h010000, 1'b0), ex(1'b0, 2'b10, 1'b0, 8'h0A));
    add(idle(1'b0), ex(1'b1, 2'b10, 1'b0, 8'h0A));
    add(idle(1'b0), ex(1'b1, 2'b10, 1'b0, 8'h0A));
    add(idle(1'b1), ex(1'b1, 2'b10, 1'b0, 8'h0A));
    add(idle(1'b1), ex(1'b1, 2'b10, 1'b1, 8'h0A));
    add(rd(24'h010000, 1'b1), ex(1'b1, 2'b10, 1'b1, 8'h0A));
    while (ps.size() > 0) begin
      drive(ps.pop_front());
      sb.push_back(pe.pop_front());
      @(negedge cpuclk_in);
      got  = {hsclk_sel, cpuclk_div_sel, cpu_rdy, cfg_q};
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL fast[%0d]: got hs=%b div=%b rdy=%b cfg=%h want hs=%b div=%b rdy=%b cfg=%h",
                 row, got[11], got[10:9], got[8], got[7:0],
                 want[11], want[10:9], want[8], want[7:0]);
      end
      row++;
      @(posedge cpuclk_in);
      #1;
    end
  endtask

  task automatic test_slow();
    exp_t got;
    exp_t want;
    int   row = 0;
    add(fetch(24'h00C000, 1'b1), ex(1'b1, 2'b10, 1'b0, 8'h0A));
    add(idle(1'b1), ex(1'b0, 2'b10, 1'b0, 8'h0A));
    add(idle(1'b0), ex(1'b0, 2'b10, 1'b0, 8'h0A));
    while (ps.size() > 0) begin
      drive(ps.pop_front());
      sb.push_back(pe.pop_front());
      @(negedge cpuclk_in);
      got  = {hsclk_sel, cpuclk_div_sel, cpu_rdy, cfg_q};
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL slow[%0d]: got hs=%b div=%b rdy=%b cfg=%h want hs=%b div=%b rdy=%b cfg=%h",
                 row, got[11], got[10:9], got[8], got[7:0],
                 want[11], want[10:9], want[8], want[7:0]);
      end
      row++;
      @(posedge cpuclk_in);
      #1;
    end
  endtask

  task automatic test_holdoff();
    exp_t got;
    exp_t want;
    int   row = 0;
`ifdef SPEEDCTRL_HOLDOFF_EN
    for (int i = 0; i < 4; i++)
      add(rd(24'h010000, 1'b0), ex(1'b0, 2'b10, 1'b1, 8'h0A));
    add(fetch(24'h00C000, 1'b0), ex(1'b0, 2'b10, 1'b1, 8'h0A));
    to_fast(HO, 2'b10, 8'h0A);
`else
    to_fast(0, 2'b10, 8'h0A);
`endif
    add(idle(1'b1), ex(1'b1, 2'b10, 1'b1, 8'h0A));
    while (ps.size() > 0) begin
      drive(ps.pop_front());
      sb.push_back(pe.pop_front());
      @(negedge cpuclk_in);
      got  = {hsclk_sel, cpuclk_div_sel, cpu_rdy, cfg_q};
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL holdoff[%0d]: got hs=%b div=%b rdy=%b cfg=%h want hs=%b div=%b rdy=%b cfg=%h",
                 row, got[11], got[10:9], got[8], got[7:0],
                 want[11], want[10:9], want[8], want[7:0]);
      end
      row++;
      @(posedge cpuclk_in);
      #1;
    end
  endtask

  task automatic test_lowram();
    exp_t got;
    exp_t want;
    int   row = 0;
    add(wr(8'h0C, 1'b1), ex(1'b1, 2'b10, 1'b1, 8'h0A));
    add(rd(24'h001234, 1'b1), ex(1'b1, 2'b10, 1'b1, 8'h0C));
    add(rd(24'h00FE40, 1'b1), ex(1'b1, 2'b10, 1'b0, 8'h0C));
    add(idle(1'b0), ex(1'b0, 2'b10, 1'b0, 8'h0C));
    add(idle(1'b0), ex(1'b0, 2'b10, 1'b1, 8'h0C));
    to_fast(HO - 1, 2'b00, 8'h0C);
    add(wr(8'h08, 1'b1), ex(1'b1, 2'b00, 1'b1, 8'h0C));
    add(rd(24'h001234, 1'b1), ex(1'b1, 2'b00, 1'b0, 8'h08));
    add(idle(1'b0), ex(1'b0, 2'b00, 1'b0, 8'h08));
    add(idle(1'b0), ex(1'b0, 2'b00, 1'b1, 8'h08));
    while (ps.size() > 0) begin
      drive(ps.pop_front());
      sb.push_back(pe.pop_front());
      @(negedge cpuclk_in);
      got  = {hsclk_sel, cpuclk_div_sel, cpu_rdy, cfg_q};
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL lowram[%0d]: got hs=%b div=%b rdy=%b cfg=%h want hs=%b div=%b rdy=%b cfg=%h",
                 row, got[11], got[10:9], got[8], got[7:0],
                 want[11], want[10:9], want[8], want[7:0]);
      end
      row++;
      @(posedge cpuclk_in);
      #1;
    end
  endtask

  task automatic test_freeze();
    exp_t got;
    exp_t want;
    int   row = 0;
    to_fast(HO - 1, 2'b00, 8'h08);
    add(wr(8'h09, 1'b1), ex(1'b1, 2'b00, 1'b1, 8'h08));
    add(idle(1'b1), ex(1'b1, 2'b00, 1'b1, 8'h09));
    add(wr(8'h01, 1'b1), ex(1'b1, 2'b00, 1'b1, 8'h09));
    add(idle(1'b1), ex(1'b1, 2'b00, 1'b0, 8'h01));
    add(idle(1'b1), ex(1'b0, 2'b00, 1'b0, 8'h01));
    add(idle(1'b0), ex(1'b0, 2'b00, 1'b0, 8'h01));
    add(idle(1'b0), ex(1'b0, 2'b00, 1'b1, 8'h01));
    add(idle(1'b0), ex(1'b0, 2'b01, 1'b1, 8'h01));
    while (ps.size() > 0) begin
      drive(ps.pop_front());
      sb.push_back(pe.pop_front());
      @(negedge cpuclk_in);
      got  = {hsclk_sel, cpuclk_div_sel, cpu_rdy, cfg_q};
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL freeze[%0d]: got hs=%b div=%b rdy=%b cfg=%h want hs=%b div=%b rdy=%b cfg=%h",
                 row, got[11], got[10:9], got[8], got[7:0],
                 want[11], want[10:9], want[8], want[7:0]);
      end
      row++;
      @(posedge cpuclk_in);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t got;
    exp_t want;
    int   row = 0;
    add(wr(8'h0B, 1'b0), ex(1'b0, 2'b01, 1'b1, 8'h01));
    add(idle(1'b0), ex(1'b0, 2'b01, 1'b1, 8'h0B));
    for (int i = 0; i < HO - 4; i++)
      add(rd(24'h010000, 1'b0), ex(1'b0, 2'b11, 1'b1, 8'h0B));
    add(rd(24'h010000, 1'b0), ex(1'b0, 2'b11, 1'b0, 8'h0B));
    add(wr(8'h03, 1'b0), ex(1'b1, 2'b11, 1'b0, 8'h0B));
    add(idle(1'b1), ex(1'b1, 2'b11, 1'b0, 8'h03));
    add(idle(1'b1), ex(1'b1, 2'b11, 1'b0, 8'h03));
    add(idle(1'b0), ex(1'b0, 2'b11, 1'b0, 8'h03));
    add(idle(1'b0), ex(1'b0, 2'b11, 1'b1, 8'h03));
    while (ps.size() > 0) begin
      drive(ps.pop_front());
      sb.push_back(pe.pop_front());
      @(negedge cpuclk_in);
      got  = {hsclk_sel, cpuclk_div_sel, cpu_rdy, cfg_q};
      want = sb.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL b2b[%0d]: got hs=%b div=%b rdy=%b cfg=%h want hs=%b div=%b rdy=%b cfg=%h",
                 row, got[11], got[10:9], got[8], got[7:0],
                 want[11], want[10:9], want[8], want[7:0]);
      end
      row++;
      @(posedge cpuclk_in);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_fast();
    test_slow();
    test_holdoff();
    test_lowram();
    test_freeze();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
